ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Fetch-stage master that produces {instF, pcF, snpcF} for the F->D pipeline register.
//  Owns the PC, runs a request/response handshake to instruction memory and holds each
//  fetched word on a valid/ready link (m_valid/m_ready) until decode accepts it.
//  Takes PC redirects from execute (branch/jump/trap) and discards stale in-flight fetches.
// PARAMETERS
//  RESET_PC   32'h80000000  PC fetched first after reset
//  ERR_INST   32'h00100073  word substituted for instF when imem_rsp_err=1 (ebreak)
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst_n           in   1   asynchronous active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  fetch address (= pc)
//  imem_rsp_valid  in   1   response word valid
//  imem_rsp_ready  out  1   fetch can take response
//  imem_rsp_data   in   32  instruction word
//  imem_rsp_err    in   1   access fault on this response
//  redirect_valid  in   1   one-cycle PC redirect strobe
//  redirect_pc     in   32  redirect target
//  m_valid         out  1   {instF,pcF,snpcF} valid to decode
//  m_ready         in   1   decode accepts
//  instF           out  32  fetched instruction
//  pcF             out  32  address of instF
//  snpcF           out  32  pcF + 4
//  misalign        out  1   redirect target misaligned (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=REQ, pc=RESET_PC, drop=0, m_valid=0, instF=0,
//   pcF=RESET_PC, snpcF=RESET_PC+4, misalign=0. First request issued cycle after deassert.
//  States: REQ -> WAIT_RSP -> HOLD -> REQ. Outputs are decoded from registered state only.
//  REQ: imem_req_valid=1, addr=pc; req handshake -> WAIT_RSP. Addr changes only on redirect.
//  WAIT_RSP: imem_rsp_ready=1; on rsp_valid: if drop -> clear drop, go REQ (word discarded);
//   else latch instF=err?ERR_INST:data, pcF=pc, snpcF=pc+4 -> HOLD.
//  HOLD: m_valid=1, outputs stable; m_valid&m_ready -> pc<=pc+4, go REQ.
//  Min latency pc->m_valid: 2 cycles (req accepted cycle 0, rsp cycle 1, m_valid cycle 2).
//  Redirect (highest priority on pc; pc<=redirect_pc in any state):
//   REQ, no req handshake: stay REQ, next addr = redirect_pc.
//   REQ with req handshake same cycle: go WAIT_RSP, drop<=1.
//   WAIT_RSP, no rsp: drop<=1. WAIT_RSP with rsp same cycle: word discarded, go REQ.
//   HOLD: m_valid drops next cycle, go REQ; if m_ready same cycle the word counts as
//   transferred, but pc<=redirect_pc (not pc+4).
//   Redirect while drop=1: pc updated, drop stays 1 (one outstanding request max).
//  Arithmetic: pc+4 and snpcF wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
//  imem_rsp_err does not stall; fault word travels to decode as ERR_INST at its pcF.
//  Never more than one outstanding imem request; imem_rsp_ready=0 outside WAIT_RSP.
// CONFIGURATION
//  IFU_MISALIGN_CHK_EN defined: redirect with redirect_pc[1:0]!=0 loads
//   {redirect_pc[31:2],2'b00} and pulses misalign=1 for the cycle after the redirect.
//  Undefined: redirect_pc loaded verbatim; misalign tied to 0.
// TESTING
//  Reset, imem ready always, 1-cycle rsp, m_ready=1 -> addrs 0x80000000,04,08 in order;
//   pcF/snpcF pairs (0x80000000,0x80000004) etc., m_valid first high 2 cycles after reset.
//  m_ready=0 for 5 cycles in HOLD -> instF/pcF stable, no new imem_req_valid; release ->
//   next req addr = pcF+4.
//  Redirect to 0x80000100 in WAIT_RSP, rsp word 0xDEADBEEF -> word never on m_valid; next
//   req addr 0x80000100.
//  Redirect in HOLD with m_ready=1 same cycle -> one transfer, next req addr = redirect_pc.
//  imem_rsp_err=1 at pc 0x80000010 -> instF=0x00100073, pcF=0x80000010.
//  PC 0xFFFFFFFC fetch -> snpcF=0x0; with IFU_MISALIGN_CHK_EN redirect 0x80000102 ->
//   req addr 0x80000100, misalign one-cycle pulse; without macro addr 0x80000102.
//  Assert rst_n low while in WAIT_RSP -> all outputs to reset values immediately.

Source files
------------

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, fetches one word at a time from imem and holds it for decode.
// Optional IFU_MISALIGN_CHK_EN: force-align redirect targets and flag misalignment.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter logic [31:0] ERR_INST = 32'h00100073
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    output logic        imem_rsp_ready,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] instF,
    output logic [31:0] pcF,
    output logic [31:0] snpcF,
    output logic        misalign
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] snpcf_q, snpcf_d;
    logic [31:0] redir_tgt;

`ifdef IFU_MISALIGN_CHK_EN
    logic mis_q;
    assign redir_tgt = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mis_q <= 1'b0;
        else        mis_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
    assign misalign = mis_q;
`else
    assign redir_tgt = redirect_pc;
    assign misalign  = 1'b0;
`endif

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign imem_rsp_ready = (state_q == S_WAIT);
    assign m_valid        = (state_q == S_HOLD);
    assign instF          = inst_q;
    assign pcF            = pcf_q;
    assign snpcF          = snpcf_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        inst_d  = inst_q;
        pcf_d   = pcf_q;
        snpcf_d = snpcf_q;
        case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    drop_d  = drop_q | redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    // A redirect racing the response makes the word stale too.
                    if (drop_q || redirect_valid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = S_HOLD;
                        inst_d  = imem_rsp_err ? ERR_INST : imem_rsp_data;
                        pcf_d   = pc_q;
                        snpcf_d = pc_q + 32'd4;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (m_ready) begin
                    state_d = S_REQ;
                    pc_d    = pc_q + 32'd4;
                end
            end
            default: state_d = S_REQ;
        endcase
        if (redirect_valid) pc_d = redir_tgt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            inst_q  <= 32'd0;
            pcf_q   <= RESET_PC;
            snpcf_q <= RESET_PC + 32'd4;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            inst_q  <= inst_d;
            pcf_q   <= pcf_d;
            snpcf_q <= snpcf_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: imem responder, fetch-stream reference model, directed scenarios.
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h80000000;
    localparam logic [31:0] ERR_INST = 32'h00100073;
    localparam logic [31:0] ERR_ADDR = 32'h80000010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0, imem_rsp_ready;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        imem_rsp_err = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        m_valid, m_ready = 1'b0;
    logic [31:0] instF, pcF, snpcF;
    logic        misalign;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .m_valid(m_valid), .m_ready(m_ready),
        .instF(instF), .pcF(pcF), .snpcF(snpcF), .misalign(misalign)
    );

    int nchk = 0, nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h80000014) ? 32'hDEADBEEF : (a ^ 32'h5A5A5A5A);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return (a == ERR_ADDR) ? ERR_INST : memf(a);
    endfunction

    function automatic logic [31:0] tgt(input logic [31:0] rp);
`ifdef IFU_MISALIGN_CHK_EN
        return {rp[31:2], 2'b00};
`else
        return rp;
`endif
    endfunction

    // stimulus knobs, applied at each negedge by cyc()
    bit          rst_v = 1'b0, rdy_v = 1'b1, mr_v = 1'b1, rd_v = 1'b0;
    logic [31:0] rp_v = 32'd0;
    int          lat = 1;
    bit          pend = 1'b0, pend0 = 1'b0;
    int          pend_dly = 0;
    logic [31:0] pend_addr = 32'd0;
    logic [31:0] acc_q[$];

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst_n = rst_v; imem_req_ready = rdy_v; m_ready = mr_v;
            redirect_valid = rd_v; redirect_pc = rp_v; rd_v = 1'b0;
            pend0 = pend;
            if (pend && pend_dly <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memf(pend_addr);
                imem_rsp_err   = (pend_addr == ERR_ADDR);
            end else begin
                imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; imem_rsp_err = 1'b0;
            end
            #1;
            if (!rst_n) pend = 1'b0;
            else begin
                if (imem_rsp_valid && imem_rsp_ready) pend = 1'b0;
                else if (pend) pend_dly--;
                if (imem_req_valid && imem_req_ready) begin
                    pend = 1'b1; pend_dly = lat; pend_addr = imem_req_addr;
                    acc_q.push_back(imem_req_addr);
                end
            end
        end
    endtask

    task automatic wait_mv(input string nm, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            n = i;
            if (m_valid) break;
        end
        if (!m_valid) chk({nm, "_timeout"}, m_valid, 1);
    endtask

    task automatic wait_req(input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cyc(1);
            hit = imem_req_valid && imem_req_ready;
        end
        if (!hit) chk({nm, "_timeout"}, 0, 1);
    endtask

    // reference model: the architectural fetch stream plus handshake rules
    logic [31:0] exp_pc = RESET_PC, hold_inst = 32'd0, hold_pc = 32'd0;
    bit          stall_prev = 1'b0, mis_prev = 1'b0, saw_dead = 1'b0;
    int          xfer_cnt = 0;

    initial forever begin
        @(negedge clk); #2;
        if (!rst_n) begin
            chk("rst_mvalid", m_valid, 0);
            chk("rst_instF", instF, 0);
            chk("rst_pcF", pcF, RESET_PC);
            chk("rst_snpcF", snpcF, RESET_PC + 32'd4);
            chk("rst_misalign", misalign, 0);
            chk("rst_rsp_ready", imem_rsp_ready, 0);
            chk("rst_addr", imem_req_addr, RESET_PC);
            exp_pc = RESET_PC; stall_prev = 1'b0; mis_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_mvalid", m_valid, 1);
                chk("stall_instF", instF, hold_inst);
                chk("stall_pcF", pcF, hold_pc);
            end
            chk("misalign", misalign, mis_prev);
            chk("one_outstanding", imem_req_valid & pend0, 0);
            if (imem_req_valid && imem_req_ready && !redirect_valid)
                chk("req_addr", imem_req_addr, exp_pc);
            if (m_valid && instF == 32'hDEADBEEF) saw_dead = 1'b1;
            if (m_valid && m_ready) begin
                chk("xfer_pcF", pcF, exp_pc);
                chk("xfer_instF", instF, exp_word(exp_pc));
                chk("xfer_snpcF", snpcF, exp_pc + 32'd4);
                xfer_cnt++;
            end
            stall_prev = m_valid && !m_ready && !redirect_valid;
            hold_inst = instF; hold_pc = pcF;
`ifdef IFU_MISALIGN_CHK_EN
            mis_prev = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
            mis_prev = 1'b0;
`endif
            if (redirect_valid) exp_pc = tgt(redirect_pc);
            else if (m_valid && m_ready) exp_pc = exp_pc + 32'd4;
        end
    end

    initial begin
        int n, xs;
        logic [31:0] spc;
        rst_v = 1'b0; cyc(3);
        rst_v = 1'b1; acc_q.delete();
        wait_mv("first_mv", n);
        chk("first_mv_latency", n, 2);
        chk("first_pcF", pcF, 32'h80000000);
        chk("first_snpcF", snpcF, 32'h80000004);
        cyc(6);
        chk("acc0", acc_q[0], 32'h80000000);
        chk("acc1", acc_q[1], 32'h80000004);
        chk("acc2", acc_q[2], 32'h80000008);

        // decode back-pressure for 5 cycles in HOLD
        mr_v = 1'b0;
        wait_mv("stall_mv", n);
        spc = pcF;
        chk("stall_at_pc", spc, 32'h8000000C);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("stall_noreq", imem_req_valid, 0);
            chk("stall_pc_lit", pcF, spc);
        end
        mr_v = 1'b1;
        wait_req("rel_req");
        chk("rel_addr", imem_req_addr, spc + 32'd4);

        wait_mv("err_mv", n);
        chk("err_instF", instF, 32'h00100073);
        chk("err_pcF", pcF, 32'h80000010);

        // redirect while the fetch of 0x80000014 (0xDEADBEEF) is in flight
        lat = 2;
        wait_req("rw_req");
        chk("rw_req_addr", imem_req_addr, 32'h80000014);
        rd_v = 1'b1; rp_v = 32'h80000100; lat = 1;
        cyc(1);
        chk("rw_in_wait", imem_rsp_ready, 1);
        wait_req("rw_next");
        chk("rw_next_addr", imem_req_addr, 32'h80000100);

        // redirect in HOLD with m_ready: one transfer, then redirect target
        cyc(1);
        rd_v = 1'b1; rp_v = 32'h80000200;
        xs = xfer_cnt;
        cyc(1);
        chk("rh_in_hold", m_valid, 1);
        wait_req("rh_next");
        chk("rh_xfers", xfer_cnt - xs, 1);
        chk("rh_next_addr", imem_req_addr, 32'h80000200);

        // redirect racing the response, to the top of the address space
        rd_v = 1'b1; rp_v = 32'hFFFFFFFC;
        cyc(1);
        wait_mv("wrap_mv", n);
        chk("wrap_pcF", pcF, 32'hFFFFFFFC);
        chk("wrap_snpcF", snpcF, 32'h00000000);
        wait_req("wrap_next");
        chk("wrap_addr", imem_req_addr, 32'h00000000);

        rd_v = 1'b1; rp_v = 32'h80000102;
        cyc(1);
        cyc(1);
`ifdef IFU_MISALIGN_CHK_EN
        chk("mis_pulse", misalign, 1);
        chk("mis_addr", imem_req_addr, 32'h80000100);
`else
        chk("mis_pulse", misalign, 0);
        chk("mis_addr", imem_req_addr, 32'h80000102);
`endif
        cyc(1);
        chk("mis_clear", misalign, 0);

        // asynchronous reset while waiting on a response
        chk("pre_rst_wait", imem_rsp_ready, 1);
        rst_n = 1'b0; rst_v = 1'b0;
        #1;
        chk("arst_mvalid", m_valid, 0);
        chk("arst_pcF", pcF, RESET_PC);
        chk("arst_snpcF", snpcF, RESET_PC + 32'd4);
        chk("arst_addr", imem_req_addr, RESET_PC);
        chk("arst_rsp_ready", imem_rsp_ready, 0);
        cyc(2);
        rst_v = 1'b1;
        wait_mv("post_rst_mv", n);
        chk("post_rst_latency", n, 2);
        chk("post_rst_pcF", pcF, RESET_PC);
        cyc(2);
        chk("deadbeef_dropped", saw_dead, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
